coin_feeder: RTL and testbench

Customer-side payment driver for the vending-machine FSM. It holds a loaded wallet of half-coins and one-coins. On `start` it transmits one coin code per `clk_slow` cycle on `step` until at least 1.5 units (3 half-units) are paid. It then checks the machine's `out` response for dispense/change and reports the result. It sits on the opposite side of the `step`/`out` interface and shares `clk_slow` and `clr` with the machine.

---
 rtl/coin_feeder.sv | 161 ++++++++++++++++
 tb/tb_coin_feeder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_feeder.sv
// coin_feeder: customer-side payment driver; pays 3 half-units from a loaded wallet one coin per cycle, then checks the machine's response.
// Latency: N coins -> coins on step at edges 0..N-1, CHECK entered at edge N, done pulses at edge N+1.
// Backpressure: none; start is ignored while busy, and vend_out is sampled only during CHECK.
// Ports: clk_slow/clr (async, active-high) | start, half_in, one_in, vend_out in |
//        step, busy, done, got_item, got_change, err, half_left, one_left, paid, items out.
module coin_feeder (
    input  logic       clk_slow,
    input  logic       clr,
    input  logic       start,
    input  logic [3:0] half_in,
    input  logic [3:0] one_in,
    input  logic [1:0] vend_out,
    output logic [1:0] step,
    output logic       busy,
    output logic       done,
    output logic       got_item,
    output logic       got_change,
    output logic       err,
    output logic [3:0] half_left,
    output logic [3:0] one_left,
    output logic [2:0] paid,
    output logic [7:0] items
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_HALF = 2'b01;
    localparam logic [1:0] CODE_ONE  = 2'b10;

    state_t     state_q, state_d;
    logic [1:0] step_d;
    logic       done_d, got_item_d, got_change_d, err_d;
    logic [3:0] half_d, one_d;
    logic [2:0] paid_d;
    logic [7:0] items_d;

    // Coin selection works on a "source" wallet: the fresh inputs when a
    // purchase is being accepted, otherwise the running registers.
    logic [3:0] src_half, src_one;
    logic [2:0] src_paid;
    logic [1:0] coin_code;
    logic [3:0] coin_half, coin_one;
    logic [2:0] coin_paid;
    logic [5:0] wallet_val;
    logic       vend_ok;

    assign busy = (state_q != IDLE);

    assign src_half = (state_q == IDLE) ? half_in : half_left;
    assign src_one  = (state_q == IDLE) ? one_in  : one_left;
    assign src_paid = (state_q == IDLE) ? 3'd0    : paid;

    always_comb begin
        coin_code = CODE_HALF;
        coin_half = src_half;
        coin_one  = src_one;
        coin_paid = src_paid + 3'd1;
        if (src_one != 4'd0) begin
            coin_code = CODE_ONE;
            coin_one  = src_one - 4'd1;
            coin_paid = src_paid + 3'd2;
        end else begin
            coin_half = src_half - 4'd1;
        end
    end

    assign wallet_val = {2'b00, half_in} + {1'b0, one_in, 1'b0};

    // Change is owed exactly when a one-coin overshot the price (paid == 4).
    assign vend_ok = vend_out[1] && (vend_out[0] == (paid == 3'd4));

    always_comb begin
        state_d      = state_q;
        step_d       = CODE_NONE;
        done_d       = 1'b0;
        got_item_d   = got_item;
        got_change_d = got_change;
        err_d        = err;
        half_d       = half_left;
        one_d        = one_left;
        paid_d       = paid;
        items_d      = items;
        case (state_q)
            IDLE: begin
                if (start) begin
                    got_item_d   = 1'b0;
                    got_change_d = 1'b0;
                    if (wallet_val < 6'd3) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                        half_d = 4'd0;
                        one_d  = 4'd0;
                        paid_d = 3'd0;
                    end else begin
                        err_d   = 1'b0;
                        step_d  = coin_code;
                        half_d  = coin_half;
                        one_d   = coin_one;
                        paid_d  = coin_paid;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (paid < 3'd3) begin
                    step_d = coin_code;
                    half_d = coin_half;
                    one_d  = coin_one;
                    paid_d = coin_paid;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                got_item_d   = vend_out[1];
                got_change_d = vend_out[0];
                err_d        = !vend_ok;
                done_d       = 1'b1;
                if (vend_ok) begin
                    items_d = items + 8'd1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_slow or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            step       <= CODE_NONE;
            done       <= 1'b0;
            got_item   <= 1'b0;
            got_change <= 1'b0;
            err        <= 1'b0;
            half_left  <= 4'd0;
            one_left   <= 4'd0;
            paid       <= 3'd0;
            items      <= 8'd0;
        end else begin
            state_q    <= state_d;
            step       <= step_d;
            done       <= done_d;
            got_item   <= got_item_d;
            got_change <= got_change_d;
            err        <= err_d;
            half_left  <= half_d;
            one_left   <= one_d;
            paid       <= paid_d;
            items      <= items_d;
        end
    end

endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder: directed purchases against a transaction-level expectation schedule.
// Each accepted start expands into a per-edge list of expected outputs; one process compares every cycle.
// Hand-written literal checks after each purchase pin the schedule builder itself.
module tb_coin_feeder;

    logic       clk_slow = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic [3:0] half_in = 4'd0;
    logic [3:0] one_in = 4'd0;
    logic [1:0] vend_out = 2'b00;
    logic [1:0] step;
    logic       busy, done, got_item, got_change, err;
    logic [3:0] half_left, one_left;
    logic [2:0] paid;
    logic [7:0] items;

    coin_feeder dut (
        .clk_slow  (clk_slow),
        .clr       (clr),
        .start     (start),
        .half_in   (half_in),
        .one_in    (one_in),
        .vend_out  (vend_out),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .got_item  (got_item),
        .got_change(got_change),
        .err       (err),
        .half_left (half_left),
        .one_left  (one_left),
        .paid      (paid),
        .items     (items)
    );

    always #5 clk_slow = ~clk_slow;

    typedef struct packed {
        logic [1:0] step;
        logic       busy;
        logic       done;
        logic       gi;
        logic       gc;
        logic       err;
        logic [3:0] hl;
        logic [3:0] ol;
        logic [2:0] paid;
        logic [7:0] items;
    } snap_t;

    localparam snap_t RST = '0;

    snap_t exp_s = RST;
    snap_t sched[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
        end
    endtask

    // Expand one purchase into the outputs expected after each clock edge,
    // starting from the currently expected (idle) outputs.
    function automatic void plan(input int h, input int o, input logic [1:0] vo);
        snap_t s;
        int    p;
        bit    ok;
        s      = exp_s;
        s.gi   = 1'b0;
        s.gc   = 1'b0;
        s.done = 1'b0;
        if (h + 2 * o < 3) begin
            s.err  = 1'b1;
            s.done = 1'b1;
            s.hl   = 4'd0;
            s.ol   = 4'd0;
            s.paid = 3'd0;
            s.step = 2'b00;
            s.busy = 1'b0;
            sched.push_back(s);
            return;
        end
        s.err  = 1'b0;
        s.busy = 1'b1;
        p = 0;
        while (p < 3) begin
            if (o > 0) begin
                o--;
                p += 2;
                s.step = 2'b10;
            end else begin
                h--;
                p += 1;
                s.step = 2'b01;
            end
            s.hl   = h[3:0];
            s.ol   = o[3:0];
            s.paid = p[2:0];
            sched.push_back(s);
        end
        s.step = 2'b00;
        sched.push_back(s);
        ok     = vo[1] && (vo[0] == (p == 4));
        s.busy = 1'b0;
        s.done = 1'b1;
        s.gi   = vo[1];
        s.gc   = vo[0];
        s.err  = !ok;
        if (ok) s.items = s.items + 8'd1;
        sched.push_back(s);
    endfunction

    always @(posedge clk_slow or posedge clr) begin
        if (clr) begin
            exp_s = RST;
            sched.delete();
        end else if (sched.size() > 0) begin
            exp_s = sched.pop_front();
        end else begin
            exp_s.done = 1'b0;
        end
    end

    always @(negedge clk_slow) begin
        chk("step", step, exp_s.step);
        chk("busy", busy, exp_s.busy);
        chk("done", done, exp_s.done);
        chk("got_item", got_item, exp_s.gi);
        chk("got_change", got_change, exp_s.gc);
        chk("err", err, exp_s.err);
        chk("half_left", half_left, exp_s.hl);
        chk("one_left", one_left, exp_s.ol);
        chk("paid", paid, exp_s.paid);
        chk("items", items, exp_s.items);
    end

    logic [1:0] obs_step[0:15];
    logic       obs_busy[0:15];
    int         lat;

    // Drives one purchase; obs_* index = edge number relative to the accepting edge,
    // lat = edge at which done was seen. quick=1 asserts start in the current
    // (done) cycle without an idle gap.
    task automatic buy(input int h, input int o, input logic [1:0] vo, input bit quick);
        int n;
        if (!quick) @(negedge clk_slow);
        half_in  = h[3:0];
        one_in   = o[3:0];
        vend_out = vo;
        start    = 1'b1;
        plan(h, o, vo);
        @(negedge clk_slow);
        start = 1'b0;
        n = 0;
        obs_step[0] = step;
        obs_busy[0] = busy;
        while (!done && n < 12) begin
            n++;
            @(negedge clk_slow);
            obs_step[n] = step;
            obs_busy[n] = busy;
        end
        lat = n;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #22 clr = 1'b0;
        chk("rst_items", items, 0);
        chk("rst_step", step, 0);
        chk("rst_busy", busy, 0);

        // Two one-coins, machine returns item + change.
        buy(0, 2, 2'b11, 0);
        chk("two1_lat", lat, 3);
        chk("two1_s0", obs_step[0], 2);
        chk("two1_s1", obs_step[1], 2);
        chk("two1_s2", obs_step[2], 0);
        chk("two1_paid", paid, 4);
        chk("two1_item", got_item, 1);
        chk("two1_chg", got_change, 1);
        chk("two1_err", err, 0);
        chk("two1_items", items, 1);
        chk("two1_oleft", one_left, 0);

        // Mixed coins, item without change.
        buy(1, 1, 2'b10, 0);
        chk("mix_lat", lat, 3);
        chk("mix_s0", obs_step[0], 2);
        chk("mix_s1", obs_step[1], 1);
        chk("mix_s2", obs_step[2], 0);
        chk("mix_paid", paid, 3);
        chk("mix_item", got_item, 1);
        chk("mix_chg", got_change, 0);
        chk("mix_err", err, 0);
        chk("mix_hleft", half_left, 0);
        chk("mix_items", items, 2);

        // Three half-coins.
        buy(3, 0, 2'b10, 0);
        chk("half3_lat", lat, 4);
        chk("half3_s0", obs_step[0], 1);
        chk("half3_s2", obs_step[2], 1);
        chk("half3_s3", obs_step[3], 0);
        chk("half3_busy0", obs_busy[0], 1);
        chk("half3_busy3", obs_busy[3], 1);
        chk("half3_busy4", obs_busy[4], 0);
        chk("half3_items", items, 3);

        // Insufficient wallet: rejected on the start edge itself.
        buy(0, 1, 2'b00, 0);
        chk("poor_lat", lat, 0);
        chk("poor_err", err, 1);
        chk("poor_step", obs_step[0], 0);
        chk("poor_busy", obs_busy[0], 0);
        chk("poor_items", items, 3);

        // Response mismatches.
        buy(3, 0, 2'b11, 0);
        chk("mm11_err", err, 1);
        chk("mm11_items", items, 3);
        buy(3, 0, 2'b00, 0);
        chk("mm00_err", err, 1);
        chk("mm00_item", got_item, 0);
        buy(15, 15, 2'b10, 0);
        chk("mm_nochg_err", err, 1);
        chk("big_oleft", one_left, 13);
        chk("big_hleft", half_left, 15);

        // Start in the done cycle is accepted; err from the previous attempt clears.
        buy(2, 1, 2'b10, 1);
        chk("b2b_lat", lat, 3);
        chk("b2b_s1", obs_step[1], 1);
        chk("b2b_err", err, 0);
        chk("b2b_items", items, 4);

        // Asynchronous clear mid-SEND.
        @(negedge clk_slow);
        half_in = 4'd3;
        one_in  = 4'd0;
        start   = 1'b1;
        plan(3, 0, 2'b10);
        @(negedge clk_slow);
        start = 1'b0;
        chk("pre_clr_busy", busy, 1);
        #2 clr = 1'b1;
        #1;
        chk("clr_step", step, 0);
        chk("clr_busy", busy, 0);
        chk("clr_paid", paid, 0);
        chk("clr_items", items, 0);
        #1 clr = 1'b0;

        // 256 back-to-back successful purchases wrap the counter.
        buy(0, 2, 2'b11, 0);
        for (int i = 1; i < 256; i++) begin
            buy(0, 2, 2'b11, 1);
            if (i == 254) chk("items_255", items, 255);
        end
        chk("items_wrap", items, 0);

        @(negedge clk_slow);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t: got 0 expected 1", $time);
        $fatal(1);
    end

endmodule
